reg_err_demux: RTL and testbench
================================

REG_ERR_DEMUX -- requirements
Module: reg_err_demux

Interface
REQ-001 SHALL have parameter NumPorts, default 4, number of register-bus targets (1..16).
REQ-002 SHALL have parameter NumRules, default 4, number of address-map rules.
REQ-003 SHALL have parameter TimeoutCycles, default 256, forward-wait cycles before abort; 0 disables the timeout.
REQ-004 SHALL have parameter ErrData, default 32'hBADCAB1E, rdata returned on any error response.
REQ-005 SHALL have type parameters req_t (addr, write, wdata, wstrb, valid), rsp_t (rdata, error, ready) and rule_t (idx, start_addr, end_addr).
REQ-006 clk_i  input  1  single clock; all state on rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 in_req_i  input  req_t  upstream request (typically the destination side of the register clock-domain crossing).
REQ-009 in_rsp_o  output  rsp_t  upstream response.
REQ-010 addr_map_i  input  NumRules x rule_t  address map; quasi-static, changed only while idle.
REQ-011 out_req_o  output  NumPorts x req_t  per-target requests.
REQ-012 out_rsp_i  input  NumPorts x rsp_t  per-target responses.
REQ-013 decode_err_o  output  1  one-cycle pulse on unmapped access.
REQ-014 timeout_o  output  1  one-cycle pulse on timeout abort.

Function
REQ-015 Handshake on either side completes in the cycle where valid and ready are both high; the initiator holds valid and fields stable until then.
REQ-016 Decode: a rule matches when start_addr <= addr < end_addr; the lowest-numbered matching rule wins; a match with idx >= NumPorts counts as a miss.
REQ-017 FSM states: Idle, Fwd, Err.
REQ-018 Idle: in_rsp_o.ready=0, all out_req_o valid=0; on in_req_i.valid, register the decoded index and go to Fwd on a hit, or to Err on a miss.
REQ-019 Fwd: out_req_o[sel] carries in_req_i fields with valid=1; in_rsp_o carries out_rsp_i[sel] unmodified, including ready and error.
REQ-020 Fwd: when out_rsp_i[sel].ready=1, the handshake completes in both directions in that cycle, and the FSM returns to Idle.
REQ-021 Non-selected out_req_o SHALL carry valid=0 in every state; their other fields are don't-care but deterministic.
REQ-022 Timeout counter: cleared on entering Fwd; increments each Fwd cycle without ready.
REQ-023 If TimeoutCycles>0 and the counter reaches TimeoutCycles-1 without ready, the FSM drops out valid next cycle, pulses timeout_o, and goes to Err.
REQ-024 If ready arrives in the same cycle the counter hits its limit, the handshake completes normally and no timeout occurs.
REQ-025 Err: in_rsp_o.ready=1, error=1, rdata=ErrData for exactly one cycle, then Idle; decode_err_o pulses in this cycle for misses only.
REQ-026 Latency: hit = 1 cycle decode, then target latency; miss = response on 2nd cycle after valid; timeout = TimeoutCycles+2 cycles.
REQ-027 The counter width SHALL be $clog2(TimeoutCycles+1), minimum 1, and SHALL never wrap.
REQ-028 Back-to-back: a new request is accepted in Idle the cycle after a completion, giving at most one transaction per two cycles.

Reset
REQ-029 Asserting rst_ni in any state SHALL force Idle, zero the counter and index, and drive all valid, ready, error, decode_err_o and timeout_o outputs to 0 asynchronously.
REQ-030 After deassertion, the first request is decoded on the first active edge.

Structure
REQ-031 rule_t and the reg-bus req/rsp typedef macros SHALL live in the shared register-interface package and include file.
REQ-032 Address decoding SHALL be a separate combinational sub-module, reg_addr_decode (addr, map -> idx, hit).

Verification
REQ-033 Map {0:[0x000,0x100), 1:[0x100,0x200)}; read 0x104 with target 1 ready after 3 cycles, rdata=0x1234 -> in_rsp rdata=0x1234, error=0, only out_req_o[1].valid asserted.
REQ-034 Write 0x300 (unmapped) -> no target valid; 2nd cycle: ready=1, error=1, rdata=0xBADCAB1E, decode_err_o pulse.
REQ-035 TimeoutCycles=8, target 0 never ready, read 0x010 -> out valid for 8 cycles, then timeout_o pulse and an error response with ErrData.
REQ-036 TimeoutCycles=8, ready on the 8th Fwd cycle -> normal completion, timeout_o stays 0.
REQ-037 Overlapping rules {0:[0x0,0x200), 1:[0x100,0x200)}, addr 0x150 -> routed to port 0.
REQ-038 Assert rst_ni low during Fwd -> all valid/ready outputs 0 immediately; the next request is decoded normally.

Source files
------------

// File: rtl/reg_err_demux_pkg.sv
// Shared register-interface types for the error-aware demux: bus request/response
// structs, address rules, FSM state encoding and sizing helpers.
package reg_err_demux_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned RuleIdxWidth = 32;

  typedef logic [AddrWidth-1:0]    addr_t;
  typedef logic [DataWidth-1:0]    data_t;
  typedef logic [StrbWidth-1:0]    strb_t;
  typedef logic [RuleIdxWidth-1:0] rule_idx_t;

  typedef struct packed {
    addr_t addr;
    logic  write;
    data_t wdata;
    strb_t wstrb;
    logic  valid;
  } reg_req_t;

  typedef struct packed {
    data_t rdata;
    logic  error;
    logic  ready;
  } reg_rsp_t;

  typedef struct packed {
    rule_idx_t idx;
    addr_t     start_addr;
    addr_t     end_addr;
  } addr_rule_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFwd  = 2'd1,
    StErr  = 2'd2
  } demux_state_e;

  // Port-select width; a single target still needs one bit.
  function automatic int unsigned idx_width(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // Wait-counter width able to hold TimeoutCycles; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    int unsigned w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_addr_decode.sv
// Combinational address decoder: first (lowest-numbered) matching rule selects the
// target; a winning rule pointing past the last port is reported as a miss.
module reg_addr_decode
  import reg_err_demux_pkg::*;
#(
  parameter int unsigned NumRules = 4,
  parameter int unsigned NumPorts = 4,
  parameter type         rule_t   = addr_rule_t
) (
  input  logic [AddrWidth-1:0]             addr,
  input  rule_t                            map [NumRules],
  output logic [idx_width(NumPorts)-1:0]   idx,
  output logic                             hit
);

  localparam int unsigned IdxWidth = idx_width(NumPorts);

  logic [NumRules-1:0] match;

  for (genvar gi = 0; gi < NumRules; gi++) begin : g_rule
    assign match[gi] = (addr >= map[gi].start_addr) && (addr < map[gi].end_addr);
  end

  // Walk from the highest rule down so the lowest matching rule is applied last.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = (map[i].idx < RuleIdxWidth'(NumPorts));
        idx = hit ? IdxWidth'(map[i].idx) : '0;
      end
    end
  end

endmodule

// File: rtl/reg_err_demux.sv
// Register-bus demultiplexer: routes one upstream request to its decoded target and
// answers unmapped or stalled accesses with a single-cycle error response.
module reg_err_demux
  import reg_err_demux_pkg::*;
#(
  parameter int unsigned          NumPorts      = 4,
  parameter int unsigned          NumRules      = 4,
  parameter int unsigned          TimeoutCycles = 256,
  parameter logic [DataWidth-1:0] ErrData       = 32'hBADCAB1E,
  parameter type                  req_t         = reg_req_t,
  parameter type                  rsp_t         = reg_rsp_t,
  parameter type                  rule_t        = addr_rule_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  req_t  in_req_i,
  output rsp_t  in_rsp_o,
  input  rule_t addr_map_i [NumRules],
  output req_t  out_req_o  [NumPorts],
  input  rsp_t  out_rsp_i  [NumPorts],
  output logic  decode_err_o,
  output logic  timeout_o
);

  localparam int unsigned IdxWidth  = idx_width(NumPorts);
  localparam int unsigned CntWidth  = cnt_width(TimeoutCycles);
  localparam bit          TimeoutEn = (TimeoutCycles != 0);
  localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TimeoutEn ? TimeoutCycles - 1 : 0);
  localparam logic [CntWidth-1:0] CntMax   = '1;

  demux_state_e          state_reg;
  logic [IdxWidth-1:0]   sel_reg;
  logic [CntWidth-1:0]   cnt_reg;
  logic                  decode_err_reg;
  logic                  timeout_reg;

  logic [IdxWidth-1:0]   dec_idx;
  logic                  dec_hit;
  rsp_t                  sel_rsp;
  logic                  timeout_hit;
  logic [NumPorts-1:0]   port_sel;

  reg_addr_decode #(
    .NumRules (NumRules),
    .NumPorts (NumPorts),
    .rule_t   (rule_t)
  ) u_decode (
    .addr (in_req_i.addr),
    .map  (addr_map_i),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

  assign sel_rsp     = out_rsp_i[sel_reg];
  assign timeout_hit = TimeoutEn && (cnt_reg == CntLimit);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= StIdle;
      sel_reg        <= '0;
      cnt_reg        <= '0;
      decode_err_reg <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      decode_err_reg <= 1'b0;
      timeout_reg    <= 1'b0;
      case (state_reg)
        StIdle: begin
          if (in_req_i.valid) begin
            sel_reg <= dec_idx;
            cnt_reg <= '0;
            if (dec_hit) begin
              state_reg <= StFwd;
            end else begin
              state_reg      <= StErr;
              decode_err_reg <= 1'b1;
            end
          end
        end
        StFwd: begin
          // A ready on the limit cycle still wins over the abort.
          if (sel_rsp.ready) begin
            state_reg <= StIdle;
          end else if (timeout_hit) begin
            state_reg   <= StErr;
            timeout_reg <= 1'b1;
          end else if (cnt_reg != CntMax) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        StErr: begin
          state_reg <= StIdle;
        end
        default: begin
          state_reg <= StIdle;
        end
      endcase
    end
  end

  assign decode_err_o = decode_err_reg;
  assign timeout_o    = timeout_reg;

  always_comb begin
    in_rsp_o = '0;
    case (state_reg)
      StFwd: begin
        in_rsp_o = sel_rsp;
      end
      StErr: begin
        in_rsp_o.rdata = ErrData;
        in_rsp_o.error = 1'b1;
        in_rsp_o.ready = 1'b1;
      end
      default: begin
        in_rsp_o = '0;
      end
    endcase
  end

  // Every target sees the upstream fields; only the selected one sees valid.
  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    assign port_sel[gi] = (state_reg == StFwd) && (sel_reg == IdxWidth'(gi));

    always_comb begin
      out_req_o[gi]       = in_req_i;
      out_req_o[gi].valid = port_sel[gi];
    end
  end

endmodule

// File: tb/tb_reg_err_demux.sv
// Directed bench for reg_err_demux: a transaction-level model predicts every output
// each cycle, plus literal pins for the key scenarios.
module tb_reg_err_demux;
  import reg_err_demux_pkg::*;

  localparam int          NP = 4;
  localparam int          NR = 4;
  localparam int          TO = 8;
  localparam logic [31:0] ED = 32'hBADCAB1E;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  reg_req_t   in_req;
  reg_rsp_t   in_rsp;
  addr_rule_t amap    [NR];
  reg_req_t   out_req [NP];
  reg_rsp_t   out_rsp [NP];
  logic       derr;
  logic       tmo;

  always #5 clk = ~clk;

  reg_err_demux #(
    .NumPorts      (NP),
    .NumRules      (NR),
    .TimeoutCycles (TO),
    .ErrData       (ED),
    .req_t         (reg_req_t),
    .rsp_t         (reg_rsp_t),
    .rule_t        (addr_rule_t)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_req_i     (in_req),
    .in_rsp_o     (in_rsp),
    .addr_map_i   (amap),
    .out_req_o    (out_req),
    .out_rsp_i    (out_rsp),
    .decode_err_o (derr),
    .timeout_o    (tmo)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state of the transaction in flight.
  bit          active = 1'b0;
  int          t0 = 0;
  int          m_port = -1;
  int          m_rdy = 0;
  logic [31:0] m_rdata = '0;
  bit          m_err = 1'b0;

  // Observations gathered over the current transaction.
  logic [NP-1:0] obs_ports;
  int            obs_vcyc;
  int            obs_hs_k;
  logic [31:0]   obs_rdata;
  logic          obs_err;
  int            obs_derr;
  int            obs_to;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Target index by the map rules: first matching rule decides, bad index is a miss.
  function automatic int model_port(input logic [31:0] a);
    for (int i = 0; i < NR; i++) begin
      if (a >= amap[i].start_addr && a < amap[i].end_addr)
        return (amap[i].idx < 32'(NP)) ? int'(amap[i].idx) : -1;
    end
    return -1;
  endfunction

  // What the addressed target drives in its k-th cycle of the transaction.
  function automatic reg_rsp_t tgt_rsp(input int k);
    reg_rsp_t r;
    r.ready = (k == m_rdy);
    r.error = r.ready & m_err;
    r.rdata = r.ready ? m_rdata : (32'hC0DE0000 | 32'(k));
    return r;
  endfunction

  task automatic drive_idle();
    for (int p = 0; p < NP; p++) begin
      out_rsp[p].rdata = 32'hEEEE0000 | 32'(p);
      out_rsp[p].error = 1'b1;
      out_rsp[p].ready = 1'b1;
    end
  endtask

  task automatic drive_rsp(input int k);
    drive_idle();
    if (m_port >= 0) out_rsp[m_port] = (k >= 1) ? tgt_rsp(k) : reg_rsp_t'('0);
  endtask

  task automatic clear_obs();
    obs_ports = '0; obs_vcyc = 0; obs_hs_k = -1; obs_rdata = '0;
    obs_err = 1'b0; obs_derr = 0; obs_to = 0;
  endtask

  task automatic set_rule(input int i, input int idx, input logic [31:0] s, input logic [31:0] e);
    amap[i].idx = 32'(idx);
    amap[i].start_addr = s;
    amap[i].end_addr = e;
  endtask

  task automatic idle(input int n);
    drive_idle();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_req(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                           input int rdy, input logic [31:0] rd, input bit rerr);
    m_port = model_port(a); m_rdy = rdy; m_rdata = rd; m_err = rerr;
    in_req.addr = a; in_req.write = wr; in_req.wdata = wd;
    in_req.wstrb = wr ? 4'hF : 4'h0; in_req.valid = 1'b1;
    t0 = cyc; active = 1'b1;
    clear_obs();
  endtask

  // Present one request from the current cycle and see it through to completion.
  task automatic run_txn(input string nm, input logic [31:0] a, input bit wr, input logic [31:0] wd,
                         input int rdy, input logic [31:0] rd, input bit rerr);
    int end_k;
    start_req(a, wr, wd, rdy, rd, rerr);
    end_k = (m_port < 0) ? 1 : ((rdy <= TO) ? rdy : TO + 1);
    for (int k = 0; k <= end_k; k++) begin
      drive_rsp(k);
      @(posedge clk); #1;
    end
    in_req.valid = 1'b0; active = 1'b0;
    drive_idle();
    $display("[TB] txn %s addr=%h port=%0d hs_cycle=%0d rdata=%h err=%0b ports=%b",
             nm, a, m_port, obs_hs_k, obs_rdata, obs_err, obs_ports);
  endtask

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin
    logic [NP-1:0] act_v, exp_v;
    reg_rsp_t      exp_r;
    logic          exp_d, exp_t;
    int            k;
    for (int p = 0; p < NP; p++) act_v[p] = out_req[p].valid;
    exp_v = '0; exp_r = '0; exp_d = 1'b0; exp_t = 1'b0;
    k = cyc - t0;
    if (rst_n && active && k >= 1) begin
      if (m_port < 0) begin
        if (k == 1) begin exp_r = '{rdata: ED, error: 1'b1, ready: 1'b1}; exp_d = 1'b1; end
      end else if (k <= m_rdy && k <= TO) begin
        exp_v[m_port] = 1'b1;
        exp_r = tgt_rsp(k);
      end else if (k == TO + 1) begin
        exp_r = '{rdata: ED, error: 1'b1, ready: 1'b1};
        exp_t = 1'b1;
      end
    end
    chk("out_valid", 64'(act_v), 64'(exp_v));
    chk("in_rsp", 64'(in_rsp), 64'(exp_r));
    chk("decode_err", 64'(derr), 64'(exp_d));
    chk("timeout", 64'(tmo), 64'(exp_t));
    if (exp_v != '0)
      chk("out_fields",
          {out_req[m_port].addr, out_req[m_port].wdata},
          {in_req.addr, in_req.wdata});
    obs_ports = obs_ports | act_v;
    if (act_v != '0) obs_vcyc++;
    if (in_req.valid && in_rsp.ready && obs_hs_k < 0) begin
      obs_hs_k = k; obs_rdata = in_rsp.rdata; obs_err = in_rsp.error;
    end
    if (derr) obs_derr++;
    if (tmo) obs_to++;
  end

  initial begin
    logic [NP-1:0] v;
    in_req = '0;
    drive_idle();
    set_rule(0, 0, 32'h000, 32'h100);
    set_rule(1, 1, 32'h100, 32'h200);
    set_rule(2, 0, 32'h0,   32'h0);
    set_rule(3, 3, 32'h800, 32'h900);
    repeat (3) begin @(posedge clk); #1; end
    for (int p = 0; p < NP; p++) v[p] = out_req[p].valid;
    chk("reset_valid", 64'(v), 64'(0));
    chk("reset_rsp", 64'(in_rsp), 64'(0));
    chk("reset_pulses", 64'({derr, tmo}), 64'(0));
    rst_n = 1'b1;

    run_txn("read_0x104", 32'h104, 1'b0, 32'h0, 3, 32'h1234, 1'b0);
    chk("r104_hs_cycle", 64'(obs_hs_k), 64'(3));
    chk("r104_rdata", 64'(obs_rdata), 64'h1234);
    chk("r104_err", 64'(obs_err), 64'(0));
    chk("r104_ports", 64'(obs_ports), 64'(4'b0010));

    run_txn("write_0x300", 32'h300, 1'b1, 32'hA5A5A5A5, 1, 32'h0, 1'b0);
    chk("w300_ports", 64'(obs_ports), 64'(0));
    chk("w300_hs_cycle", 64'(obs_hs_k), 64'(1));
    chk("w300_rdata", 64'(obs_rdata), 64'hBADCAB1E);
    chk("w300_err", 64'(obs_err), 64'(1));
    chk("w300_decode_err", 64'(obs_derr), 64'(1));

    idle(2);
    run_txn("timeout_0x010", 32'h010, 1'b0, 32'h0, 1000, 32'h0, 1'b0);
    chk("to_valid_cycles", 64'(obs_vcyc), 64'(8));
    chk("to_pulse", 64'(obs_to), 64'(1));
    chk("to_hs_cycle", 64'(obs_hs_k), 64'(9));
    chk("to_rdata", 64'(obs_rdata), 64'hBADCAB1E);
    chk("to_decode_err", 64'(obs_derr), 64'(0));

    run_txn("late_ready_0x010", 32'h010, 1'b0, 32'h0, 8, 32'h0000CAFE, 1'b0);
    chk("late_hs_cycle", 64'(obs_hs_k), 64'(8));
    chk("late_timeout", 64'(obs_to), 64'(0));
    chk("late_rdata", 64'(obs_rdata), 64'h0000CAFE);

    // Back-to-back and boundary addresses on the base map.
    run_txn("edge_0x0ff", 32'h0FF, 1'b1, 32'h11111111, 1, 32'h1, 1'b0);
    run_txn("edge_0x100_err", 32'h100, 1'b0, 32'h0, 2, 32'h2, 1'b1);
    chk("tgt_err_passthru", 64'(obs_err), 64'(1));
    run_txn("edge_0x1ff", 32'h1FF, 1'b0, 32'h0, 1, 32'h3, 1'b0);
    run_txn("edge_0x200", 32'h200, 1'b0, 32'h0, 1, 32'h0, 1'b0);
    chk("e200_decode_err", 64'(obs_derr), 64'(1));
    run_txn("port3_0x8fc", 32'h8FC, 1'b1, 32'h33333333, 4, 32'h4, 1'b0);
    chk("p3_ports", 64'(obs_ports), 64'(4'b1000));

    idle(1);
    set_rule(0, 0, 32'h000, 32'h200);
    set_rule(1, 1, 32'h100, 32'h200);
    run_txn("overlap_0x150", 32'h150, 1'b0, 32'h0, 2, 32'h5150, 1'b0);
    chk("ovl_ports", 64'(obs_ports), 64'(4'b0001));

    idle(1);
    set_rule(0, 9, 32'h400, 32'h500);
    set_rule(1, 2, 32'h000, 32'h500);
    set_rule(2, 3, 32'h500, 32'h600);
    set_rule(3, 7, 32'h600, 32'h700);
    run_txn("badidx_0x450", 32'h450, 1'b0, 32'h0, 1, 32'h0, 1'b0);
    chk("bad_ports", 64'(obs_ports), 64'(0));
    chk("bad_decode_err", 64'(obs_derr), 64'(1));
    run_txn("rule1_0x050", 32'h050, 1'b0, 32'h0, 2, 32'h2222, 1'b0);
    chk("r1_ports", 64'(obs_ports), 64'(4'b0100));
    run_txn("rule2_0x5ff", 32'h5FF, 1'b0, 32'h0, 1, 32'h3333, 1'b0);
    run_txn("rule3_0x600", 32'h600, 1'b0, 32'h0, 1, 32'h0, 1'b0);

    // Reset asserted mid-forward must clear outputs without waiting for a clock.
    idle(1);
    start_req(32'h020, 1'b0, 32'h0, 1000, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive_rsp(k);
      @(posedge clk); #1;
    end
    drive_rsp(3);
    #1;
    for (int p = 0; p < NP; p++) v[p] = out_req[p].valid;
    chk("pre_rst_valid", 64'(v), 64'(4'b0100));
    rst_n = 1'b0; active = 1'b0;
    #1;
    for (int p = 0; p < NP; p++) v[p] = out_req[p].valid;
    chk("rst_async_valid", 64'(v), 64'(0));
    chk("rst_async_rsp", 64'({in_rsp.ready, in_rsp.error}), 64'(0));
    in_req.valid = 1'b0;
    drive_idle();
    $display("[TB] txn reset_mid_fwd addr=00000020 aborted");
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    run_txn("post_rst_0x050", 32'h050, 1'b1, 32'h77777777, 1, 32'h7, 1'b0);
    chk("post_rst_hs_cycle", 64'(obs_hs_k), 64'(1));
    chk("post_rst_ports", 64'(obs_ports), 64'(4'b0100));

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
